iob_fifo_wr_arbiter: RTL
========================

# iob_fifo_wr_arbiter

Round-robin burst arbiter that shares the single write port of an `iob_sync_assim_fifo` among `N_REQ` requesters. A requester receives a grant only when the FIFO has room for a maximum-size burst. Once granted, it owns the write port until its burst ends, so a burst never stalls on `full`. The block sits between producer engines and the FIFO write side. It reads the FIFO's `fifo_ocupancy`, which counts narrow units.

## Interface
- `N_REQ`, 4: number of requesters, at least 2.
- `DATA_W`, 32: FIFO write-port width (`W_DATA_W`).
- `W_UNITS`, 4: occupancy units per written word (`W_DATA_W` / min(`W_DATA_W`, `R_DATA_W`)).
- `FIFO_CAP`, 16: FIFO capacity in occupancy units.
- `BURST_MAX`, 2: maximum words per grant. `BURST_MAX*W_UNITS` must be at most `FIFO_CAP`; elaboration fails otherwise.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in `N_REQ`: per-requester word valid.
- `req_last` in `N_REQ`: marks the final word of the requester's burst.
- `req_data` in `N_REQ*DATA_W`: requester i occupies bits [i*DATA_W +: DATA_W].
- `req_ready` out `N_REQ`: the word is accepted this cycle.
- `grant` out `N_REQ`: one-hot current owner, registered.
- `busy` out 1: a burst is in progress (state BURST).
- `fifo_ocupancy` in 32: FIFO occupancy in units.
- `fifo_full` in 1: FIFO full flag.
- `fifo_write_en` out 1: FIFO write strobe.
- `fifo_data_in` out `DATA_W`: FIFO write data.
- `err` out 1: sticky flag, set if a write is issued while `fifo_full` is high.

## Operation
- States: IDLE and BURST.
- Registers:
  - `grant` (one-hot).
  - round-robin pointer `rr` (index).
  - beat counter `cnt`, width clog2(`BURST_MAX`+1).
  - `err`.
- `free = FIFO_CAP - fifo_ocupancy`, computed at 33 bits unsigned. If `fifo_ocupancy > FIFO_CAP`, `free` is treated as 0.
- IDLE:
  - A requester is eligible when its `req_valid` is 1.
  - If any requester is eligible and `free >= BURST_MAX*W_UNITS`, the first eligible index found searching upward from `rr` (with wrap) is granted. Next state is BURST, `cnt`=0.
  - Otherwise stay in IDLE with `grant`=0.
- BURST:
  - `req_ready[i] = grant[i]` (combinational from the registered grant). Space is guaranteed by the grant-time reservation, so `req_ready` does not depend on `req_valid`.
  - A beat occurs when `req_valid[g]` and `grant[g]` are both 1. On a beat: `fifo_write_en`=1, `fifo_data_in = req_data[g]`, `cnt` increments.
  - The burst ends on a beat with `req_last[g]`=1, or on the beat that makes `cnt == BURST_MAX`.
  - At burst end: next state IDLE, `grant` clears, `rr = (g+1) mod N_REQ`.
  - If the owner drops `req_valid` mid-burst, the grant is held, no beat occurs, and there is no timeout.
- `fifo_data_in` is 0 whenever `fifo_write_en` is 0.
- `req_valid` and `req_last` from non-granted requesters are ignored.
- `fifo_ocupancy` changes caused by concurrent reads only increase `free`. They never revoke a grant.
- `err` sets on `fifo_write_en & fifo_full` and clears only on reset.

## Timing
- Reset (`rst`=0, asynchronous) values: state IDLE, `grant`=0, `busy`=0, `req_ready`=0, `fifo_write_en`=0, `fifo_data_in`=0, `rr`=0, `cnt`=0, `err`=0. A reset in mid-burst abandons the partial burst immediately.
- Grant latency: eligibility sampled at edge k gives `grant` valid after edge k, so the first beat can occur in cycle k+1.
- Write path: `fifo_write_en` and `fifo_data_in` are combinational in the beat cycle. The FIFO captures them on the next edge.
- Burst end: `grant` deasserts after the edge that captures the last beat. IDLE lasts at least one cycle, so back-to-back bursts are separated by exactly one idle cycle.
- Simultaneous events:
  - `req_last` on the `BURST_MAX`th beat ends the burst once.
  - A requester with `req_last` on its first beat yields a single-word burst.
- Wrap-around: `rr` wraps from `N_REQ-1` to 0.

## Test plan
Defaults for all scenarios: `N_REQ`=4, `DATA_W`=32, `W_UNITS`=4, `FIFO_CAP`=16, `BURST_MAX`=2, with a real `iob_sync_assim_fifo` (32-bit write, 8-bit read) attached.
- Reset, idle inputs: all outputs 0; `grant`=0000 for 10 cycles.
- Requester 0 sends 0x03020100 then 0x07060504 (`req_last` on the second), occupancy 0 → `grant`=0001 one cycle after valid; two `fifo_write_en` pulses; `grant`=0000 afterwards; `fifo_ocupancy`=8; draining 8 bytes returns 0x00..0x07 in order.
- All four requesters valid continuously, 2-word bursts, FIFO drained continuously → grants in order 0001, 0010, 0100, 1000, 0001, with one idle cycle between bursts; `err`=0.
- Space gating:
  - occupancy 12 (free 4, below 8) with requester 1 valid → no grant.
  - read one word so occupancy falls to 8 → `grant`=0010 on the following edge.
- Requester 2 granted and drops `req_valid` for 3 cycles after its first beat → `grant` stays 0100, `fifo_write_en` stays 0 for those cycles; the second beat completes the burst (`BURST_MAX` reached, no `req_last`).
- `rst` pulled low during requester 3's first beat → `grant`, `busy`, and `fifo_write_en` are 0 immediately; after release with requesters 1 and 3 valid, requester 1 is granted first (`rr`=0).

Source files
------------

// File: rtl/iob_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// iob_fifo_wr_arbiter
//
// Round-robin burst arbiter sharing the single write port of an
// iob_sync_assim_fifo among N_REQ requesters. A grant is only handed out when
// the FIFO has room for a full BURST_MAX-word burst, so once a requester owns
// the port its burst can never stall on fifo_full.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   req_valid      per-requester word valid
//   req_last       per-requester final-word marker
//   req_data       packed requester data, requester i at [i*DATA_W +: DATA_W]
//   req_ready      word accepted this cycle (equals the registered grant)
//   grant          one-hot current owner, registered
//   busy           a burst is in progress
//   fifo_ocupancy  FIFO occupancy in narrow units
//   fifo_full      FIFO full flag
//   fifo_write_en  FIFO write strobe (combinational in the beat cycle)
//   fifo_data_in   FIFO write data, zero when no write
//   err            sticky: a write was issued while fifo_full was high
// ---------------------------------------------------------------------------
module iob_fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int W_UNITS   = 4,
    parameter int FIFO_CAP  = 16,
    parameter int BURST_MAX = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_last,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy,
    input  logic [31:0]              fifo_ocupancy,
    input  logic                     fifo_full,
    output logic                     fifo_write_en,
    output logic [DATA_W-1:0]        fifo_data_in,
    output logic                     err
);

    localparam int RR_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    // Space a grant must reserve, in occupancy units.
    localparam logic [32:0] NEED  = 33'(BURST_MAX * W_UNITS);
    localparam logic [32:0] CAP33 = 33'(FIFO_CAP);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    if (N_REQ < 2) begin : g_bad_nreq
        $error("iob_fifo_wr_arbiter: N_REQ must be at least 2");
    end
    if (BURST_MAX < 1) begin : g_bad_burst
        $error("iob_fifo_wr_arbiter: BURST_MAX must be at least 1");
    end
    if (BURST_MAX * W_UNITS > FIFO_CAP) begin : g_bad_cap
        $error("iob_fifo_wr_arbiter: BURST_MAX*W_UNITS exceeds FIFO_CAP");
    end

    logic [0:0]       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [RR_W-1:0]  rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Free space with an occupancy above capacity clamped to zero rather than
    // wrapping to a huge unsigned value.
    logic [32:0] occ33;
    logic [32:0] free;
    logic        space_ok;

    assign occ33    = {1'b0, fifo_ocupancy};
    assign free     = (occ33 > CAP33) ? 33'd0 : (CAP33 - occ33);
    assign space_ok = (free >= NEED);

    // Signals of the current owner. grant_q is only non-zero in BURST, so a
    // beat implies the BURST state.
    logic              beat;
    logic              owner_last;
    logic [DATA_W-1:0] owner_data;
    logic [RR_W-1:0]   owner_idx;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        owner_idx  = '0;
        owner_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                owner_idx  = RR_W'(i);
                owner_data = req_data[i*DATA_W +: DATA_W];
            end
        end
        beat       = |(req_valid & grant_q);
        owner_last = |(req_last & grant_q);
    end

    // Round-robin pick: first valid requester searching upward from rr_q.
    logic            pick_found;
    logic [RR_W-1:0] pick_idx;

    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_q) + k) % N_REQ;
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick_idx   = RR_W'(idx);
            end
        end
    end

    logic [CNT_W-1:0] cnt_inc;
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (pick_found && space_ok) begin
                    state_d = ST_BURST;
                    grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    cnt_d   = '0;
                end
            end
            ST_BURST: begin
                // A stalled owner keeps the grant indefinitely; the space it
                // reserved stays reserved.
                if (beat) begin
                    cnt_d = cnt_inc;
                    if (owner_last || (cnt_inc == CNT_W'(BURST_MAX))) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        rr_d    = (owner_idx == RR_W'(N_REQ - 1)) ? '0
                                                                  : owner_idx + RR_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign err_d = err_q | (fifo_write_en & fifo_full);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign grant         = grant_q;
    assign req_ready     = grant_q;
    assign busy          = (state_q == ST_BURST);
    assign fifo_write_en = beat;
    assign fifo_data_in  = beat ? owner_data : '0;
    assign err           = err_q;

endmodule
